// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer between the load/store path and a
// single-ported data memory. Stores are queued and drained one per cycle
// whenever a load does not need the port; loads always win the port.
//
// Optional feature macro: STORE_BUF_FWD_EN
//   defined   : loads see buffered stores through youngest-match forwarding,
//               ld_stall is tied low.
//   undefined : a load matching any buffered address stalls (no port grant)
//               until the matching entries have drained to memory.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   st_valid/st_addr/st_data         store request
//   st_ready                         buffer accepts a store this cycle
//   ld_req/ld_addr                   load request (combinational, one cycle)
//   ld_data                          load result, same cycle
//   ld_stall                         load cannot complete this cycle
//   flush_req                        request a full drain
//   flush_done                       one-cycle pulse when the drain completes
//   empty, count                     occupancy status
//   mem_address/mem_dataIn           data memory address / write data
//   mem_memRead/mem_memWrite         data memory enables (never both high)
//   mem_dataOut                      data memory read data
module store_buffer #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  output logic                         st_ready,
  input  logic                         ld_req,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         ld_stall,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_dataIn,
  output logic                         mem_memRead,
  output logic                         mem_memWrite,
  input  logic [DATA_W-1:0]            mem_dataOut
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head, tail;

  logic push, pop, ld_grant, ld_hit;
  logic [PTR_W-1:0]  idx;

  // Status derived only from registered state (no path from ld_req)
  assign st_ready   = (count < CNT_W'(DEPTH)) && (state_q == RUN);
  assign empty      = (count == '0);
  assign flush_done = (state_q == DONE);

  assign push = st_valid && st_ready;

  // Match search over live entries, oldest to youngest so the youngest wins
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;

  always_comb begin
    ld_hit   = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        ld_hit   = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  assign ld_stall = 1'b0;
  assign ld_data  = !ld_req ? '0 : (ld_hit ? fwd_data : mem_dataOut);
`else
  always_comb begin
    ld_hit = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        ld_hit = 1'b1;
      end
    end
  end

  // A matching load waits for its stores to reach memory, then reads there
  assign ld_stall = ld_req && ld_hit;
  assign ld_data  = (ld_req && !ld_hit) ? mem_dataOut : '0;
`endif

  // Port arbitration: load first, then drain of the head entry
  assign ld_grant = ld_req && !ld_stall;
  assign pop      = !ld_grant && (count != '0);

  always_comb begin
    mem_memRead  = 1'b0;
    mem_memWrite = 1'b0;
    mem_address  = '0;
    mem_dataIn   = '0;
    if (ld_grant) begin
      mem_memRead = 1'b1;
      mem_address = ld_addr;
    end else if (pop) begin
      mem_memWrite = 1'b1;
      mem_address  = ent_addr[head];
      mem_dataIn   = ent_data[head];
    end
  end

  // Pointers, occupancy and entry valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry payload storage; qualified by ent_valid so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

  // Flush FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush FSM next state; flush_req only matters in RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   if (count == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule
